// File: rtl/uop_buffer.sv
// uop_buffer: circular buffer of instruction bundles with random-access reads.
//
// Producers append at the tail (wr_valid/wr_ready handshake), the consumer frees
// the oldest entry at the head (free_valid) and may read any entry by index with
// one cycle of latency. flush clears the whole buffer synchronously.
//
// Parameters:
//   UOP_BUF_SIZE        number of entries, power of two, >= 2
//   instruction_bundle  bundle type; BW = $bits(instruction_bundle)
//
// Ports:
//   clk         sole clock, posedge
//   reset       asynchronous active-low reset
//   wr_valid    producer offers wr_bundle
//   wr_ready    buffer can accept a bundle this cycle
//   wr_bundle   bundle appended at tail_addr
//   free_valid  release the head entry (ignored when empty)
//   flush       synchronous clear, highest priority
//   uop_addr    consumer read index
//   uop         registered contents of entry uop_addr
//   uop_valid   registered flag: entry uop_addr was occupied
//   head_addr   oldest entry
//   tail_addr   next write slot
//   count       occupied entries, 0..UOP_BUF_SIZE
//
// Build option:
//   UOP_BUF_BYPASS_EN  when defined, a read of the slot being written in the same
//                      cycle returns wr_bundle (valid) instead of the old contents.

module uop_buffer #(
  parameter int unsigned UOP_BUF_SIZE = 8,
  parameter type instruction_bundle = logic [31:0],
  localparam int unsigned AW = $clog2(UOP_BUF_SIZE),
  localparam int unsigned BW = $bits(instruction_bundle)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [BW-1:0] wr_bundle,
  input  logic          free_valid,
  input  logic          flush,
  input  logic [AW-1:0] uop_addr,
  output logic [BW-1:0] uop,
  output logic          uop_valid,
  output logic [AW-1:0] head_addr,
  output logic [AW-1:0] tail_addr,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FullCount = (AW+1)'(UOP_BUF_SIZE);

  logic [BW-1:0] mem [UOP_BUF_SIZE];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [BW-1:0] uop_q, uop_d;
  logic          uop_valid_q, uop_valid_d;

  logic          wr_fire;
  logic          free_fire;
  logic [AW-1:0] rd_off;
  logic          rd_occupied;

  assign wr_ready  = (count_q != FullCount);
  assign wr_fire   = wr_valid && wr_ready && !flush;
  assign free_fire = free_valid && (count_q != '0) && !flush;

  // Distance from head, modulo the buffer size; occupied iff it is below count.
  assign rd_off      = uop_addr - head_q;
  assign rd_occupied = ({1'b0, rd_off} < count_q);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_fire)   tail_d = tail_q + AW'(1);
      if (free_fire) head_d = head_q + AW'(1);
      unique case ({wr_fire, free_fire})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    uop_d       = mem[uop_addr];
    uop_valid_d = rd_occupied && !flush;
`ifdef UOP_BUF_BYPASS_EN
    // wr_fire already excludes flush cycles.
    if (wr_fire && (uop_addr == tail_q)) begin
      uop_d       = wr_bundle;
      uop_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      uop_q       <= '0;
      uop_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      uop_q       <= uop_d;
      uop_valid_q <= uop_valid_d;
    end
  end

  // Storage is not reset; stale contents are masked by uop_valid.
  always_ff @(posedge clk) begin
    if (wr_fire && reset) begin
      mem[tail_q] <= wr_bundle;
    end
  end

  assign head_addr = head_q;
  assign tail_addr = tail_q;
  assign count     = count_q;
  assign uop       = uop_q;
  assign uop_valid = uop_valid_q;

endmodule

// File: tb/tb_uop_buffer.sv
// Bench for uop_buffer (UOP_BUF_SIZE = 8, 32-bit bundles). Stimulus pushes the
// expected read response into a queue; a monitor pops and compares one cycle later.
module tb_uop_buffer;

  localparam int unsigned Size = 8;
`ifdef UOP_BUF_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_bundle;
  logic        free_valid;
  logic        flush;
  logic [2:0]  uop_addr;
  logic [31:0] uop;
  logic        uop_valid;
  logic [2:0]  head_addr;
  logic [2:0]  tail_addr;
  logic [3:0]  count;

  logic        rd_req;
  logic        mon_pend;

  typedef struct packed {
    logic [31:0] u;
    logic        v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uop_buffer #(.UOP_BUF_SIZE(Size)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_bundle  (wr_bundle),
    .free_valid (free_valid),
    .flush      (flush),
    .uop_addr   (uop_addr),
    .uop        (uop),
    .uop_valid  (uop_valid),
    .head_addr  (head_addr),
    .tail_addr  (tail_addr),
    .count      (count)
  );

  // Read monitor: captures the request at the edge, checks the registered result.
  always @(posedge clk) begin
    exp_t e;
    mon_pend = rd_req;
    #2;
    if (mon_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_underflow got uop=%0h valid=%0b want no read", uop, uop_valid);
      end else begin
        e = exp_q.pop_front();
        if (uop_valid !== e.v || (e.v && uop !== e.u)) begin
          errors++;
          $display("FAIL read got uop=%0h valid=%0b want uop=%0h valid=%0b",
                   uop, uop_valid, e.u, e.v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic cyc(input logic wv, input logic [31:0] wb, input logic fv, input logic fl,
                     input logic rd, input logic [2:0] ra, input logic [31:0] eu,
                     input logic ev);
    wr_valid   = wv;
    wr_bundle  = wb;
    free_valid = fv;
    flush      = fl;
    rd_req     = rd;
    uop_addr   = ra;
    if (rd) exp_q.push_back('{u: eu, v: ev});
    @(negedge clk);
    wr_valid   = 1'b0;
    free_valid = 1'b0;
    flush      = 1'b0;
    rd_req     = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] eu, input logic ev);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, a, eu, ev);
  endtask

  task automatic fr();
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
  endtask

  task automatic fl();
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
  endtask

  task automatic chk_state(input string tag, input logic [3:0] c, input logic [2:0] h,
                           input logic [2:0] t, input logic r);
    chk({tag, "_count"}, 32'(count), 32'(c));
    chk({tag, "_head"}, 32'(head_addr), 32'(h));
    chk({tag, "_tail"}, 32'(tail_addr), 32'(t));
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'(r));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    wr_valid   = 1'b0;
    wr_bundle  = '0;
    free_valid = 1'b0;
    flush      = 1'b0;
    uop_addr   = '0;
    rd_req     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_state("reset", 4'd0, 3'd0, 3'd0, 1'b1);
    chk("reset_uop", uop, 32'h0);
    chk("reset_uop_valid", 32'(uop_valid), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Empty buffer: write slot 0 while reading slot 0.
    cyc(1'b1, 32'hCAFE0000, 1'b0, 1'b0, 1'b1, 3'd0, 32'hCAFE0000, Byp);
    chk_state("bypass", 4'd1, 3'd0, 3'd1, 1'b1);

    // Flush beats write, free and read.
    cyc(1'b1, 32'hDEAD0001, 1'b1, 1'b1, 1'b1, 3'd0, 32'h0, 1'b0);
    chk_state("flush", 4'd0, 3'd0, 3'd0, 1'b1);
    fr();
    chk_state("free_empty", 4'd0, 3'd0, 3'd0, 1'b1);
    rd(3'd0, 32'h0, 1'b0);

    // A, B, C then read index 1.
    wr(32'h0000000A);
    wr(32'h0000000B);
    wr(32'h0000000C);
    rd(3'd1, 32'h0000000B, 1'b1);
    chk_state("abc", 4'd3, 3'd0, 3'd3, 1'b1);

    // Simultaneous write and free, 5 cycles: slots 3..7 get 0x50..0x54.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h50 + i, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    chk_state("wr_free", 4'd3, 3'd5, 3'd0, 1'b1);
    rd(3'd6, 32'h53, 1'b1);
    rd(3'd0, 32'h0, 1'b0);

    // Fill to full, overflow attempt, then free while full.
    fl();
    for (int i = 0; i < 8; i++) wr(32'h100 + i);
    chk_state("full", 4'd8, 3'd0, 3'd0, 1'b0);
    cyc(1'b1, 32'h1FF, 1'b0, 1'b0, 1'b1, 3'd0, 32'h100, 1'b1);
    chk_state("overflow", 4'd8, 3'd0, 3'd0, 1'b0);
    cyc(1'b1, 32'h1FE, 1'b1, 1'b0, 1'b1, 3'd0, 32'h100, 1'b1);
    chk_state("full_free", 4'd7, 3'd1, 3'd0, 1'b1);
    rd(3'd0, 32'h0, 1'b0);

    // Fill 8, free 6, write 4 more: wrapped occupancy 6..7,0..3.
    fl();
    for (int i = 0; i < 8; i++) wr(32'h200 + i);
    for (int i = 0; i < 6; i++) fr();
    chk_state("freed6", 4'd2, 3'd6, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) wr(32'h300 + i);
    chk_state("wrap", 4'd6, 3'd6, 3'd4, 1'b1);
    rd(3'd0, 32'h300, 1'b1);
    rd(3'd5, 32'h0, 1'b0);
    rd(3'd7, 32'h207, 1'b1);
    rd(3'd3, 32'h303, 1'b1);
    rd(3'd4, 32'h0, 1'b0);
    cyc(1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 3'd4, 32'h400, Byp);
    chk_state("wrap_bypass", 4'd7, 3'd6, 3'd5, 1'b1);

    // Asynchronous reset mid-operation.
    #2;
    reset = 1'b0;
    #1;
    chk_state("mid_reset", 4'd0, 3'd0, 3'd0, 1'b1);
    chk("mid_reset_uop_valid", 32'(uop_valid), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rd(3'd6, 32'h0, 1'b0);
    chk_state("after_reset", 4'd0, 3'd0, 3'd0, 1'b1);

    @(negedge clk);
    @(negedge clk);
    chk("read_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
